nvram_upload_reader: RTL and testbench

- Serves HPS ioctl upload (save) requests by reading bytes from a core-side byte RAM (hiscore/NVRAM region) and returning them on ioctl_din.
- It is the reverse-direction counterpart of the ROM/DIP download path in the emu top.
- Sits between hps_io upload signals and a shared RAM read port that is arbitrated against the game CPU through a request/grant handshake.
- Throttles HPS with ioctl_wait until each byte is valid.

---
 rtl/core_pkg.sv | 20 ++
 rtl/nvram_rd_port.sv | 57 +++++
 rtl/nvram_upload_reader.sv | 144 ++++++++++++++
 tb/tb_nvram_upload_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the ioctl upload/download paths.
package core_pkg;

    localparam int unsigned IOCTL_AW = 27;
    localparam int unsigned CNT_W    = 3;

    localparam logic [7:0] OOR_BYTE    = 8'hFF;
    localparam logic [7:0] INDEX_ROM   = 8'd0;
    localparam logic [7:0] INDEX_NVRAM = 8'd4;
    localparam logic [7:0] INDEX_DIP   = 8'd254;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SESSION,
        FETCH,
        LAT
    } state_t;

endpackage

// File: rtl/nvram_rd_port.sv
// Request/grant and read-latency sequencer for a shared, arbitrated byte RAM port.
module nvram_rd_port
    import core_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start_c,
    input  logic          abort_c,
    input  logic [AW-1:0] addr,
    input  logic          ram_gnt,
    output logic          ram_req,
    output logic [AW-1:0] ram_addr,
    output logic          granted_c,
    output logic          done_c
);

    logic             r_req;
    logic             r_lat;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_addr;

    assign granted_c = r_req & ram_gnt;
    // Data is taken on the edge where the counter steps from 1 to 0.
    assign done_c    = r_lat & (r_cnt == CNT_W'(1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_lat  <= 1'b0;
            r_cnt  <= '0;
            r_addr <= '0;
        end else if (abort_c) begin
            r_req <= 1'b0;
            r_lat <= 1'b0;
            r_cnt <= '0;
        end else if (start_c) begin
            r_req  <= 1'b1;
            r_addr <= addr;
        end else if (granted_c) begin
            r_req <= 1'b0;
            r_lat <= 1'b1;
            r_cnt <= CNT_W'(RD_LAT);
        end else if (r_lat) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_lat <= 1'b0;
            end
        end
    end

    assign ram_req  = r_req;
    assign ram_addr = r_addr;

endmodule

// File: rtl/nvram_upload_reader.sv
// Serves HPS ioctl upload reads from a core-side byte RAM, throttling HPS with ioctl_wait.
module nvram_upload_reader
    import core_pkg::*;
#(
    parameter int unsigned AW     = 10,
    parameter int unsigned SIZE   = 1024,
    parameter int unsigned RD_LAT = 2,
    parameter logic [7:0]  INDEX  = INDEX_NVRAM
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                save_req,
    input  logic                ioctl_upload,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    output logic                ioctl_upload_req,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,
    output logic                ram_req,
    input  logic                ram_gnt,
    output logic [AW-1:0]       ram_addr,
    input  logic [7:0]          ram_dout,
    output logic                busy
);

    localparam logic [IOCTL_AW-1:0] SIZE_L = IOCTL_AW'(SIZE);

    state_t     r_state, w_state_nxt;
    logic       r_wait, w_wait_nxt;
    logic       r_upreq, w_upreq_nxt;
    logic [7:0] r_din, w_din_nxt;
    logic       r_busy;
    logic       w_active, w_oor;
    logic       w_start, w_abort;
    logic       w_granted, w_done;

    assign w_active = ioctl_upload && (ioctl_index == INDEX);
    assign w_oor    = (ioctl_addr >= SIZE_L);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= 1'b0;
            r_upreq <= 1'b0;
            r_din   <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_upreq <= w_upreq_nxt;
            r_din   <= w_din_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_upreq_nxt = 1'b0;
        w_din_nxt   = r_din;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_wait_nxt = 1'b0;
                if (save_req) begin
                    w_state_nxt = REQ;
                    w_upreq_nxt = 1'b1;
                end else if (w_active) begin
                    w_state_nxt = SESSION;
                end
            end
            REQ: begin
                w_upreq_nxt = 1'b1;
                if (w_active) begin
                    w_state_nxt = SESSION;
                    w_upreq_nxt = 1'b0;
                end
            end
            SESSION: begin
                if (!w_active) begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 1'b0;
                end else if (ioctl_rd && !r_wait) begin
                    // Bytes past SIZE answer immediately without touching the RAM port.
                    if (w_oor) begin
                        w_din_nxt = OOR_BYTE;
                    end else begin
                        w_start     = 1'b1;
                        w_wait_nxt  = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!w_active) begin
                    w_abort     = 1'b1;
                    w_wait_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_granted) begin
                    w_state_nxt = LAT;
                end
            end
            LAT: begin
                if (!w_active) begin
                    w_abort     = 1'b1;
                    w_wait_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (w_done) begin
                    w_din_nxt   = ram_dout;
                    w_wait_nxt  = 1'b0;
                    w_state_nxt = SESSION;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = 1'b0;
            end
        endcase
    end

    nvram_rd_port #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_port (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start_c   (w_start),
        .abort_c   (w_abort),
        .addr      (ioctl_addr[AW-1:0]),
        .ram_gnt   (ram_gnt),
        .ram_req   (ram_req),
        .ram_addr  (ram_addr),
        .granted_c (w_granted),
        .done_c    (w_done)
    );

    assign ioctl_upload_req = r_upreq;
    assign ioctl_din        = r_din;
    assign ioctl_wait       = r_wait;
    assign busy             = r_busy;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Bench for nvram_upload_reader: behavioural RAM with fixed read latency plus directed and random reads.
module tb_nvram_upload_reader;

    localparam int unsigned AW     = 10;
    localparam int unsigned SIZE   = 1024;
    localparam int unsigned RD_LAT = 2;

    logic          clk_sys;
    logic          reset;
    logic          save_req;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [26:0]   ioctl_addr;
    logic          ioctl_upload_req;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          ram_req;
    logic          ram_gnt;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]    mem [SIZE];
    logic [7:0]    last_din;
    logic [7:0]    junk;
    logic [AW-1:0] p_addr [RD_LAT];
    logic          p_vld  [RD_LAT];

    nvram_upload_reader #(
        .AW     (AW),
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT),
        .INDEX  (8'd4)
    ) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .save_req         (save_req),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_upload_req (ioctl_upload_req),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait),
        .ram_req          (ram_req),
        .ram_gnt          (ram_gnt),
        .ram_addr         (ram_addr),
        .ram_dout         (ram_dout),
        .busy             (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // RAM samples the address on a granted edge; data is valid RD_LAT cycles after the grant cycle.
    always @(posedge clk_sys) begin
        p_vld[0]  <= ram_req && ram_gnt;
        p_addr[0] <= ram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            p_vld[i]  <= p_vld[i-1];
            p_addr[i] <= p_addr[i-1];
        end
    end
    always @(negedge clk_sys) junk <= 8'($urandom);
    assign ram_dout = (p_vld[RD_LAT-1] === 1'b1) ? mem[p_addr[RD_LAT-1]] : junk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One read: grant after g stall cycles, check latency and returned byte.
    task automatic do_read(input logic [26:0] a, input int g, input bit viol);
        logic [7:0] exp_d;
        int         exp_lat;
        int         n;
        bit         inr;
        inr     = (a < 27'(SIZE));
        exp_d   = inr ? mem[a[AW-1:0]] : 8'hFF;
        exp_lat = RD_LAT + 2 + g;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        n = 1;
        if (!inr) begin
            check("oor_wait", 32'(ioctl_wait), 32'd0);
            check("oor_req", 32'(ram_req), 32'd0);
            check("oor_din", 32'(ioctl_din), 32'hFF);
            @(negedge clk_sys);
            check("oor_wait2", 32'(ioctl_wait), 32'd0);
            check("oor_req2", 32'(ram_req), 32'd0);
            last_din = 8'hFF;
            return;
        end
        check("wait_rise", 32'(ioctl_wait), 32'd1);
        for (int k = 0; k < g; k++) begin
            check("stall_req", 32'(ram_req), 32'd1);
            check("stall_addr", 32'(ram_addr), 32'(a[AW-1:0]));
            if (viol && k == 0) begin
                ioctl_rd   = 1'b1;
                ioctl_addr = a ^ 27'd1;
            end
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            n++;
        end
        check("gnt_req", 32'(ram_req), 32'd1);
        check("gnt_addr", 32'(ram_addr), 32'(a[AW-1:0]));
        ram_gnt = 1'b1;
        @(negedge clk_sys);
        ram_gnt = 1'b0;
        n++;
        check("req_drop", 32'(ram_req), 32'd0);
        while (ioctl_wait === 1'b1 && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("din", 32'(ioctl_din), 32'(exp_d));
        last_din = exp_d;
    endtask

    initial begin
        logic [26:0] a;
        int          g;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA7;
        reset        = 1'b1;
        save_req     = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ram_gnt      = 1'b0;
        last_din     = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("rst_upreq", 32'(ioctl_upload_req), 32'd0);
        check("rst_din", 32'(ioctl_din), 32'h00);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_ramreq", 32'(ram_req), 32'd0);
        check("rst_ramaddr", 32'(ram_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Wrong index: no response at all
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd3;
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd5;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wrongidx_wait", 32'(ioctl_wait), 32'd0);
            check("wrongidx_busy", 32'(busy), 32'd0);
            check("wrongidx_req", 32'(ram_req), 32'd0);
            @(negedge clk_sys);
        end
        ioctl_upload = 1'b0;
        @(negedge clk_sys);

        // OSD-initiated save
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        check("save_upreq", 32'(ioctl_upload_req), 32'd1);
        check("save_busy", 32'(busy), 32'd1);
        check("save_wait", 32'(ioctl_wait), 32'd0);
        save_req = 1'b1;
        @(negedge clk_sys);
        save_req = 1'b0;
        check("req_hold", 32'(ioctl_upload_req), 32'd1);
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        @(negedge clk_sys);
        check("sess_upreq", 32'(ioctl_upload_req), 32'd0);
        check("sess_busy", 32'(busy), 32'd1);

        do_read(27'd5, 0, 1'b0);
        do_read(27'd5, 6, 1'b1);
        do_read(27'd1023, 3, 1'b0);
        do_read(27'd1024, 0, 1'b0);
        repeat (3) @(negedge clk_sys);
        check("din_hold", 32'(ioctl_din), 32'hFF);
        do_read(27'h7FFFFFF, 0, 1'b0);
        do_read(27'd0, 1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 9) == 0) a = 27'(SIZE + $urandom_range(0, 5000));
            else a = 27'($urandom_range(0, SIZE - 1));
            g = int'($urandom_range(0, 5));
            do_read(a, g, (g > 0) && t[0]);
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        // Abort while in LAT
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd9;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        ram_gnt  = 1'b1;
        @(negedge clk_sys);
        ram_gnt      = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort_lat_wait", 32'(ioctl_wait), 32'd0);
        check("abort_lat_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_sys);
        check("abort_lat_din", 32'(ioctl_din), 32'(last_din));

        // Host-initiated session, no save_req
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("host_busy", 32'(busy), 32'd1);
        check("host_upreq", 32'(ioctl_upload_req), 32'd0);
        do_read(27'd5, 2, 1'b0);

        // Abort while in FETCH with no grant yet
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd7;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("abort_fetch_req0", 32'(ram_req), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort_fetch_req", 32'(ram_req), 32'd0);
        check("abort_fetch_busy", 32'(busy), 32'd0);
        check("abort_fetch_wait", 32'(ioctl_wait), 32'd0);

        // Reset during FETCH
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'd11;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("rstf_req0", 32'(ram_req), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("rstf_req", 32'(ram_req), 32'd0);
        check("rstf_wait", 32'(ioctl_wait), 32'd0);
        check("rstf_busy", 32'(busy), 32'd0);
        check("rstf_din", 32'(ioctl_din), 32'h00);
        @(negedge clk_sys);
        do_read(27'd5, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
